// File: rtl/row_readout_ctrl.sv
// Row readout controller: pops one 136-bit row from a sync FIFO and serves it
// to the QSPI side as nine 16-bit beats (eight tile A/B byte pairs, then the
// address byte duplicated). Keeps sent/dropped row counts and an underrun flag.
module row_readout_ctrl #(
    parameter int DWIDTH = 136,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              abort,
    input  logic              clr_stat,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rdata,
    input  logic              spi_req,
    output logic              spi_valid,
    output logic              spi_last,
    output logic [15:0]       spi_data,
    output logic              row_done,
    output logic              busy,
    output logic [CNTW-1:0]   rows_sent,
    output logic [7:0]        drop_cnt,
    output logic              underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SERVE
    } state_e;

    localparam logic [3:0] LAST_BEAT = 4'd8;

    state_e            state_q, state_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic [DWIDTH-1:0] row_q, row_d;
    logic              row_done_q, row_done_d;
    logic [CNTW-1:0]   rows_sent_q, rows_sent_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              underrun_q, underrun_d;

    // Register all state; everything resets, including the row buffer, so no
    // stale row data can be observed after a reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its next-state input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= 4'd0;
            row_q       <= '0;
            row_done_q  <= 1'b0;
            rows_sent_q <= '0;
            drop_cnt_q  <= 8'd0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            row_q       <= row_d;
            row_done_q  <= row_done_d;
            rows_sent_q <= rows_sent_d;
            drop_cnt_q  <= drop_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state, FIFO pop strobe and status updates; abort overrides all.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        row_d       = row_q;
        row_done_d  = 1'b0;
        rows_sent_d = rows_sent_q;
        drop_cnt_d  = drop_cnt_q;
        underrun_d  = underrun_q;
        fifo_rd_en  = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            beat_cnt_d = 4'd0;
            // A row has only been popped once we are past FETCH.
            if ((state_q == S_WAIT || state_q == S_SERVE) && drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en && !fifo_empty) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    row_d      = fifo_rdata;
                    beat_cnt_d = 4'd0;
                    state_d    = S_SERVE;
                end
                S_SERVE: begin
                    if (spi_req) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_d     = S_IDLE;
                            beat_cnt_d  = 4'd0;
                            row_done_d  = 1'b1;
                            rows_sent_d = rows_sent_q + CNTW'(1);
                        end else begin
                            beat_cnt_d = beat_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Host asked for a beat while none was on offer.
            if (spi_req && state_q != S_SERVE) begin
                underrun_d = 1'b1;
            end
        end

        if (clr_stat) begin
            rows_sent_d = '0;
            drop_cnt_d  = 8'd0;
            underrun_d  = 1'b0;
        end
    end

    // Beat multiplexer: beat k pairs tile A byte k with tile B byte k, MSB first;
    // the final beat carries the address byte twice. Zero while not serving.
    always_comb begin
        spi_data = 16'h0000;
        if (state_q == S_SERVE) begin
            if (beat_cnt_q == LAST_BEAT) begin
                spi_data = {row_q[7:0], row_q[7:0]};
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (beat_cnt_q == 4'(k)) begin
                        spi_data = {row_q[DWIDTH-1-8*k -: 8], row_q[DWIDTH-65-8*k -: 8]};
                    end
                end
            end
        end
    end

    assign spi_valid = (state_q == S_SERVE);
    assign spi_last  = (state_q == S_SERVE) && (beat_cnt_q == LAST_BEAT);
    assign busy      = (state_q != S_IDLE);
    assign row_done  = row_done_q;
    assign rows_sent = rows_sent_q;
    assign drop_cnt  = drop_cnt_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_row_readout_ctrl.sv
// Bench for row_readout_ctrl: a small FIFO model feeds rows, directed stimulus
// pushes hand-computed beats into a scoreboard, and a negedge monitor pops and
// compares every accepted beat plus row_done, hold, latency and gap behaviour.
module tb_row_readout_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    localparam logic [135:0] ROW_A = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'h5A};
    localparam logic [135:0] ROW_B = {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 8'h3C};
    localparam logic [135:0] ROW_C = {64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 8'hC7};

    logic [15:0] beats_a [9] = '{16'h01FE, 16'h23DC, 16'h45BA, 16'h6798, 16'h8976,
                                 16'hAB54, 16'hCD32, 16'hEF10, 16'h5A5A};
    logic [15:0] beats_b [9] = '{16'h0088, 16'h1199, 16'h22AA, 16'h33BB, 16'h44CC,
                                 16'h55DD, 16'h66EE, 16'h77FF, 16'h3C3C};
    logic [15:0] beats_c [9] = '{16'hA0B0, 16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hA4B4,
                                 16'hA5B5, 16'hA6B6, 16'hA7B7, 16'hC7C7};

    logic          clk = 1'b0;
    logic          rst_n, en, abort, clr_stat, spi_req;
    logic          fifo_empty, fifo_rd_en;
    logic [135:0]  fifo_rdata = '0;
    logic          spi_valid, spi_last, row_done, busy, underrun;
    logic [15:0]   spi_data;
    logic [15:0]   rows_sent;
    logic [7:0]    drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: memory and write pointer owned by stimulus, read side by the pop process.
    logic [135:0] fifo_mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Scoreboard and monitor bookkeeping.
    beat_t exp_q [$];
    int    cyc = 0;
    int    rd_cnt = 0;
    int    done_cnt = 0;
    int    rd_cyc = -1;
    int    done_cyc = -1;
    logic  exp_done = 1'b0;
    logic  hold_pend = 1'b0;
    logic  valid_prev = 1'b0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    row_readout_ctrl #(.DWIDTH(136), .CNTW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .abort      (abort),
        .clr_stat   (clr_stat),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .spi_req    (spi_req),
        .spi_valid  (spi_valid),
        .spi_last   (spi_last),
        .spi_data   (spi_data),
        .row_done   (row_done),
        .busy       (busy),
        .rows_sent  (rows_sent),
        .drop_cnt   (drop_cnt),
        .underrun   (underrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read side of the FIFO: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_rdata <= fifo_mem[rd_ptr % 16];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Monitor: pops the scoreboard on each accepted beat and checks timing rules.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (fifo_rd_en) begin
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (spi_valid && !valid_prev) begin
            check("fetch_to_valid", 64'(cyc - rd_cyc), 64'd2);
            if (done_cyc >= 0) check("row_gap_ge3", 64'((cyc - done_cyc) >= 3), 64'd1);
        end
        if (row_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (row_done || exp_done) check("row_done", 64'(row_done), 64'(exp_done));
        exp_done = 1'b0;
        if (hold_pend && spi_valid) check("beat_hold", 64'(spi_data), 64'(held));
        hold_pend = 1'b0;
        if (spi_valid && !spi_req) begin
            hold_pend = 1'b1;
            held      = spi_data;
        end
        if (!spi_valid && spi_req) check("idle_data_zero", 64'(spi_data), 64'd0);
        if (spi_valid && spi_req && !abort && rst_n) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_data", 64'(spi_data), 64'(e.data));
                check("beat_last", 64'(spi_last), 64'(e.last));
                if (e.last) exp_done = 1'b1;
            end
        end
        valid_prev = spi_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [135:0] row);
        fifo_mem[wr_ptr % 16] = row;
        wr_ptr++;
    endtask

    task automatic push_exp(input int which, input int first, input int n);
        beat_t b;
        for (int i = first; i < first + n; i++) begin
            b.data = (which == 0) ? beats_a[i] : (which == 1) ? beats_b[i] : beats_c[i];
            b.last = (i == 8);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name, input int start);
        int n = 0;
        while (done_cnt == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(done_cnt - start), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_beat(input string name, input logic [15:0] val);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < 200) begin
            step();
            hit = spi_valid && (spi_data == val);
            n++;
        end
        check(name, 64'(hit), 64'd1);
    endtask

    initial begin
        int d0, r0;
        rst_n = 1'b0; en = 1'b0; abort = 1'b0; clr_stat = 1'b0; spi_req = 1'b0;
        #2;
        check("rst_spi_valid", 64'(spi_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_spi_data", 64'(spi_data), 64'd0);
        check("rst_rows_sent", 64'(rows_sent), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;

        // Single row, host always ready.
        d0 = done_cnt; r0 = rd_cnt;
        push_row(ROW_A);
        push_exp(0, 0, 9);
        en = 1'b1; spi_req = 1'b1;
        wait_done("t1_done", d0);
        check("t1_rows_sent", 64'(rows_sent), 64'd1);
        check("t1_pops", 64'(rd_cnt - r0), 64'd1);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Same row, host ready toggling every three cycles.
        d0 = done_cnt; r0 = rd_cnt;
        push_row(ROW_A);
        push_exp(0, 0, 9);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            spi_req = ((i / 3) % 2) == 0;
            step();
        end
        check("t2_done", 64'(done_cnt - d0), 64'd1);
        check("t2_rows_sent", 64'(rows_sent), 64'd2);
        check("t2_pops", 64'(rd_cnt - r0), 64'd1);
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort at beat 4 with a second row queued.
        spi_req = 1'b0; clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        d0 = done_cnt;
        push_row(ROW_B);
        push_row(ROW_C);
        push_exp(1, 0, 4);
        push_exp(2, 0, 9);
        spi_req = 1'b1;
        wait_beat("t3_reach_beat4", beats_b[4]);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("t3_idle_after_abort", 64'(busy), 64'd0);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        wait_done("t3_done", d0);
        check("t3_rows_sent", 64'(rows_sent), 64'd1);
        check("t3_drop_hold", 64'(drop_cnt), 64'd1);
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Empty FIFO: requests only raise underrun; clear beats a same-cycle set.
        spi_req = 1'b0; clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        @(negedge clk);
        check("t4_underrun_clr", 64'(underrun), 64'd0);
        check("t4_rows_clr", 64'(rows_sent), 64'd0);
        check("t4_drop_clr", 64'(drop_cnt), 64'd0);
        r0 = rd_cnt;
        step();
        spi_req = 1'b1;
        step();
        spi_req = 1'b0;
        @(negedge clk);
        check("t4_underrun_set", 64'(underrun), 64'd1);
        check("t4_no_valid", 64'(spi_valid), 64'd0);
        check("t4_no_pop", 64'(rd_cnt - r0), 64'd0);
        step();
        spi_req = 1'b1; clr_stat = 1'b1;
        step();
        spi_req = 1'b0; clr_stat = 1'b0;
        @(negedge clk);
        check("t4_clr_wins", 64'(underrun), 64'd0);

        // Enable dropped at beat 2: row completes, nothing further fetched.
        d0 = done_cnt; r0 = rd_cnt;
        push_row(ROW_A);
        push_row(ROW_B);
        push_exp(0, 0, 9);
        spi_req = 1'b1;
        wait_beat("t5_reach_beat2", beats_a[2]);
        en = 1'b0;
        wait_done("t5_done", d0);
        repeat (10) step();
        check("t5_pops", 64'(rd_cnt - r0), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset during beat 5 of row B; row C then plays in full.
        push_row(ROW_C);
        push_exp(1, 0, 5);
        push_exp(2, 0, 9);
        en = 1'b1;
        wait_beat("t6_reach_beat5", beats_b[5]);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(spi_valid), 64'd0);
        check("t6_rst_last", 64'(spi_last), 64'd0);
        check("t6_rst_data", 64'(spi_data), 64'd0);
        check("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rows", 64'(rows_sent), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt), 64'd0);
        check("t6_rst_underrun", 64'(underrun), 64'd0);
        check("t6_rst_done", 64'(row_done), 64'd0);
        check("t6_sb_partial", 64'(exp_q.size()), 64'd9);
        step();
        step();
        rst_n = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check("t6_idle_after_rst", 64'(busy), 64'd0);
        wait_done("t6_done", d0);
        check("t6_rows_sent", 64'(rows_sent), 64'd1);
        check("t6_drop_zero", 64'(drop_cnt), 64'd0);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

        spi_req = 1'b0; en = 1'b0;
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/row_readout_ctrl.md
ROW_READOUT_CTRL -- requirements
Module: row_readout_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 136, FIFO row width; only 136 supported (64b tile A, 64b tile B, 8b address).
REQ-002 SHALL have parameter CNTW, default 16, width of rows_sent counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  readout enable; gates new row fetches only.
REQ-006 abort  input  1  QSPI transaction terminated; discard row in flight.
REQ-007 clr_stat  input  1  synchronous clear of rows_sent, drop_cnt, underrun.
REQ-008 fifo_empty  input  1  sync FIFO empty flag.
REQ-009 fifo_rd_en  output  1  FIFO pop strobe, one cycle per row.
REQ-010 fifo_rdata  input  DWIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 spi_req  input  1  QSPI consumes current beat.
REQ-012 spi_valid, spi_last  output  1 each  beat available; beat is the address beat.
REQ-013 spi_data  output  16  current beat.
REQ-014 row_done  output  1  one-cycle pulse after final beat accepted.
REQ-015 busy  output  1  state not IDLE.
REQ-016 rows_sent  output  CNTW; drop_cnt  output  8; underrun  output  1  status.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, SERVE.
REQ-018 IDLE -> FETCH when en=1, fifo_empty=0, abort=0; else remain IDLE.
REQ-019 fifo_rd_en SHALL equal (state==FETCH && !abort), combinational; FETCH -> WAIT unconditionally absent abort.
REQ-020 WAIT SHALL capture fifo_rdata into 136b row register, clear beat_cnt (4b) to 0, go to SERVE.
REQ-021 Latency: fifo_empty=0 sampled in IDLE at edge N -> fifo_rd_en high cycle N..N+1 -> spi_valid high from edge N+2 (3 cycles IDLE-to-valid).
REQ-022 spi_valid SHALL be 1 iff state==SERVE; spi_last = SERVE && beat_cnt==8.
REQ-023 Beat k (0..7): spi_data[15:8]=row[135-8k -: 8], spi_data[7:0]=row[71-8k -: 8].
REQ-024 Beat 8: spi_data = {row[7:0], row[7:0]}.
REQ-025 spi_data SHALL be 16'h0000 when spi_valid=0.
REQ-026 Accept = spi_valid && spi_req; beat_cnt increments per accept, holds otherwise (spi_data stable).
REQ-027 Accept at beat 8: next state IDLE, row_done=1 next cycle, rows_sent increments (wraps at 2^CNTW).
REQ-028 en deassertion SHALL NOT interrupt FETCH/WAIT/SERVE; current row completes.
REQ-029 abort=1 in any state SHALL force IDLE next cycle, beat_cnt=0, no row_done, no rows_sent increment.
REQ-030 abort in WAIT or SERVE SHALL increment drop_cnt, saturating at 255; abort in IDLE/FETCH SHALL NOT (no pop occurs).
REQ-031 underrun SHALL set sticky when spi_req=1 && spi_valid=0 && abort=0.
REQ-032 clr_stat SHALL win over simultaneous increment/set of any status field.
REQ-033 Back-to-back rows: after row_done, next row spi_valid no earlier than 3 cycles later (IDLE revisit mandatory).

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, beat_cnt 0, row register 0, all outputs 0 (fifo_rd_en, spi_valid, spi_last, spi_data, row_done, busy, rows_sent, drop_cnt, underrun).
REQ-035 Reset mid-row SHALL discard row without drop_cnt increment; first cycle after release SHALL be IDLE.

Verification
REQ-036 Row {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'h5A}, spi_req always 1 -> beats 16'h01FE,23DC,45BA,6798,8976,AB54,CD32,EF10,5A5A; spi_last only on last; row_done once; rows_sent=1.
REQ-037 Same row, spi_req toggling every 3 cycles -> each beat held stable until accepted, identical 9-beat sequence, exactly one fifo_rd_en.
REQ-038 abort at beat 4 with second row queued -> state IDLE, drop_cnt=1, row_done absent, next fetch delivers second row from beat 0.
REQ-039 fifo_empty=1, en=1, spi_req pulsed -> no fifo_rd_en, spi_valid=0, underrun=1; clr_stat same cycle as another spi_req -> underrun=0.
REQ-040 en dropped at beat 2 -> row completes all 9 beats, no further fetch while en=0 and fifo_empty=0.
REQ-041 rst_n asserted during SERVE beat 5 -> all outputs 0 immediately; after release, full row replayed from next FIFO entry, drop_cnt=0.
